// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM between two req/ack requesters,
// with round-robin or fixed-priority selection and a fixed RAM read latency.
`default_nettype none
`timescale 1ns/1ps

module ram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 2,
  parameter int FIXED_PRIO   = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] address_ram,
  output logic [DATA_W-1:0] data_ram,
  output logic              wren_ram,
  input  logic [DATA_W-1:0] q_ram,
  output logic              busy,
  output logic              last_grant
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {IDLE, WRITE, WAIT, DONE} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               wren_q, wren_d;
  logic               ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               win;

  // Tie-break: alternate against the previous grant unless port 0 is fixed winner.
  always_comb begin
    if (m0_req && m1_req) begin
      win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end else begin
      win = m1_req;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wren_d   = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = win;
          last_d  = win;
          addr_d  = win ? m1_addr : m0_addr;
          data_d  = win ? m1_wdata : m0_wdata;
          if (win ? m1_we : m0_we) begin
            wren_d  = 1'b1;
            state_d = WRITE;
          end else begin
            cnt_d   = CNT_W'(READ_LATENCY);
            state_d = WAIT;
          end
        end
      end
      WRITE: begin
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        state_d = DONE;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q) rdata1_d = q_ram;
          else         rdata0_d = q_ram;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      last_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
    end
  end

  assign m0_ack      = ack0_q;
  assign m1_ack      = ack1_q;
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign address_ram = addr_q;
  assign data_ram    = data_q;
  assign wren_ram    = wren_q;
  assign busy        = busy_q;
  assign last_grant  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter in three configurations
// (round-robin RL=2, fixed-priority RL=2, round-robin RL=3), each with its own RAM model.
`default_nettype none
`timescale 1ns/1ps

module tb_ram_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_mem = 1'b1;

  logic        m0_req [N];
  logic        m0_we  [N];
  logic [15:0] m0_addr [N];
  logic [15:0] m0_wdata [N];
  logic        m0_ack [N];
  logic [15:0] m0_rdata [N];
  logic        m1_req [N];
  logic        m1_we  [N];
  logic [15:0] m1_addr [N];
  logic [15:0] m1_wdata [N];
  logic        m1_ack [N];
  logic [15:0] m1_rdata [N];
  logic [15:0] addr [N];
  logic [15:0] wdat [N];
  logic        wren [N];
  logic [15:0] q [N];
  logic        busy [N];
  logic        lg [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < N; k++) begin : g_dut
      localparam int RL = (k == 2) ? 3 : 2;
      localparam int FP = (k == 1) ? 1 : 0;
      logic [15:0] mem [256];
      logic [15:0] p1, p2;

      ram_arbiter #(
        .ADDR_W(16), .DATA_W(16), .READ_LATENCY(RL), .FIXED_PRIO(FP)
      ) u_dut (
        .clock(clk), .reset_n(rst_n),
        .m0_req(m0_req[k]), .m0_we(m0_we[k]), .m0_addr(m0_addr[k]), .m0_wdata(m0_wdata[k]),
        .m0_ack(m0_ack[k]), .m0_rdata(m0_rdata[k]),
        .m1_req(m1_req[k]), .m1_we(m1_we[k]), .m1_addr(m1_addr[k]), .m1_wdata(m1_wdata[k]),
        .m1_ack(m1_ack[k]), .m1_rdata(m1_rdata[k]),
        .address_ram(addr[k]), .data_ram(wdat[k]), .wren_ram(wren[k]), .q_ram(q[k]),
        .busy(busy[k]), .last_grant(lg[k])
      );

      // RAM model: a read of the address presented after edge E is sampled valid at edge E+RL.
      always @(posedge clk) begin
        if (init_mem) begin
          for (int i = 0; i < 256; i++) begin
            mem[i] <= (k == 2 && i == 5) ? 16'hBEEF : 16'(32'h1000 + i);
          end
        end else if (wren[k]) begin
          mem[addr[k][7:0]] <= wdat[k];
        end
        p1 <= addr[k];
        p2 <= p1;
      end
      assign q[k] = (RL == 3) ? mem[p2[7:0]] : mem[p1[7:0]];
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      m0_req[k] = 1'b0; m0_we[k] = 1'b0; m0_addr[k] = '0; m0_wdata[k] = '0;
      m1_req[k] = 1'b0; m1_we[k] = 1'b0; m1_addr[k] = '0; m1_wdata[k] = '0;
    end

    // Reset held with a pending port 0 write
    m0_req[0] = 1'b1; m0_we[0] = 1'b1; m0_addr[0] = 16'h0010; m0_wdata[0] = 16'h1234;
    repeat (3) nxt;
    init_mem = 1'b0;
    chk("rst_m0_ack",   32'(m0_ack[0]),   0);
    chk("rst_m1_ack",   32'(m1_ack[0]),   0);
    chk("rst_m0_rdata", 32'(m0_rdata[0]), 0);
    chk("rst_m1_rdata", 32'(m1_rdata[0]), 0);
    chk("rst_addr",     32'(addr[0]),     0);
    chk("rst_data",     32'(wdat[0]),     0);
    chk("rst_wren",     32'(wren[0]),     0);
    chk("rst_busy",     32'(busy[0]),     0);
    chk("rst_lg",       32'(lg[0]),       1);
    rst_n = 1'b1;

    // Port 0 write
    nxt;
    chk("wr_wren",  32'(wren[0]),   1);
    chk("wr_addr",  32'(addr[0]),   'h0010);
    chk("wr_data",  32'(wdat[0]),   'h1234);
    chk("wr_lg",    32'(lg[0]),     0);
    chk("wr_busy",  32'(busy[0]),   1);
    chk("wr_ack_early", 32'(m0_ack[0]), 0);
    nxt;
    chk("wr_wren_off", 32'(wren[0]),   0);
    chk("wr_ack",      32'(m0_ack[0]), 1);
    m0_req[0] = 1'b0;
    nxt;
    chk("wr_ack_pulse", 32'(m0_ack[0]), 0);
    chk("wr_idle_busy", 32'(busy[0]),   0);

    // Port 1 reads back the written word
    m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 16'h0010;
    nxt;
    chk("rd_lg",   32'(lg[0]),     1);
    chk("rd_wren", 32'(wren[0]),   0);
    chk("rd_busy", 32'(busy[0]),   1);
    chk("rd_ack_c1", 32'(m1_ack[0]), 0);
    nxt;
    chk("rd_ack_c2", 32'(m1_ack[0]), 0);
    nxt;
    chk("rd_ack",      32'(m1_ack[0]),   1);
    chk("rd_rdata",    32'(m1_rdata[0]), 'h1234);
    chk("rd_m0_ack",   32'(m0_ack[0]),   0);
    chk("rd_m0_rdata", 32'(m0_rdata[0]), 0);
    m1_req[0] = 1'b0;
    nxt;
    chk("rd_ack_pulse", 32'(m1_ack[0]), 0);
    chk("rd_idle_busy", 32'(busy[0]),   0);

    // Round-robin with both ports requesting reads continuously
    m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 16'h0010;
    m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 16'h0020;
    for (int t = 0; t < 4; t++) begin
      int p;
      p = t % 2;
      nxt;
      chk("rr_lg",   32'(lg[0]),   p);
      chk("rr_busy", 32'(busy[0]), 1);
      nxt;
      chk("rr_acks_c2", {30'd0, m1_ack[0], m0_ack[0]}, 0);
      nxt;
      chk("rr_acks", {30'd0, m1_ack[0], m0_ack[0]}, (p == 1) ? 2 : 1);
      chk("rr_rdata", 32'((p == 1) ? m1_rdata[0] : m0_rdata[0]), (p == 1) ? 'h1020 : 'h1234);
      nxt;
      chk("rr_acks_off", {30'd0, m1_ack[0], m0_ack[0]}, 0);
      chk("rr_idle", 32'(busy[0]), 0);
    end
    m0_req[0] = 1'b0; m1_req[0] = 1'b0;

    // Fixed priority: port 0 held wins every time, port 1 after port 0 drops
    m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_addr[1] = 16'h0030;
    m1_req[1] = 1'b1; m1_we[1] = 1'b0; m1_addr[1] = 16'h0040;
    for (int t = 0; t < 3; t++) begin
      nxt;
      chk("fp_lg", 32'(lg[1]), 0);
      nxt;
      nxt;
      chk("fp_m0_ack",   32'(m0_ack[1]),   1);
      chk("fp_m1_ack",   32'(m1_ack[1]),   0);
      chk("fp_m0_rdata", 32'(m0_rdata[1]), 'h1030);
      nxt;
      chk("fp_m0_ack_off", 32'(m0_ack[1]), 0);
    end
    m0_req[1] = 1'b0;
    nxt;
    chk("fp_m1_lg",   32'(lg[1]),   1);
    chk("fp_m1_busy", 32'(busy[1]), 1);
    nxt;
    nxt;
    chk("fp_m1_ack",   32'(m1_ack[1]),   1);
    chk("fp_m1_rdata", 32'(m1_rdata[1]), 'h1040);
    chk("fp_m0_quiet", 32'(m0_ack[1]),   0);
    m1_req[1] = 1'b0;
    nxt;
    chk("fp_m1_ack_off", 32'(m1_ack[1]), 0);

    // Reset during WAIT of a port 1 read aborts it
    m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 16'h0020;
    nxt;
    chk("ab_busy_pre", 32'(busy[0]), 1);
    nxt;
    rst_n = 1'b0;
    #1;
    chk("ab_busy",  32'(busy[0]),     0);
    chk("ab_wren",  32'(wren[0]),     0);
    chk("ab_ack",   32'(m1_ack[0]),   0);
    chk("ab_rdata", 32'(m1_rdata[0]), 0);
    chk("ab_lg",    32'(lg[0]),       1);
    chk("ab_addr",  32'(addr[0]),     0);
    m1_req[0] = 1'b0;
    nxt;
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      nxt;
      chk("ab_no_ack",  32'(m1_ack[0]), 0);
      chk("ab_no_busy", 32'(busy[0]),   0);
    end

    // READ_LATENCY=3, address changes mid-WAIT are ignored
    m0_req[2] = 1'b1; m0_we[2] = 1'b0; m0_addr[2] = 16'h0005;
    nxt;
    chk("rl3_addr0", 32'(addr[2]), 'h0005);
    chk("rl3_busy",  32'(busy[2]), 1);
    m0_addr[2] = 16'h0007;
    nxt;
    chk("rl3_ack_c2", 32'(m0_ack[2]), 0);
    chk("rl3_addr1",  32'(addr[2]),   'h0005);
    nxt;
    chk("rl3_ack_c3", 32'(m0_ack[2]), 0);
    nxt;
    chk("rl3_ack",   32'(m0_ack[2]),   1);
    chk("rl3_rdata", 32'(m0_rdata[2]), 'hBEEF);
    chk("rl3_addr2", 32'(addr[2]),     'h0005);
    m0_req[2] = 1'b0;
    nxt;
    chk("rl3_ack_off", 32'(m0_ack[2]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter sharing the single-port data RAM between the stack-machine core (port 0) and a second requester (port 1), such as the I/O sync engine or a debug/loader block.
- Owns the RAM address, write-data and write-enable lines.
- Serialises transactions with a req/ack handshake and honours the fixed RAM read latency.
- Selects between ports by round-robin or fixed priority.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 16, RAM data width
READ_LATENCY, 2, rising edges from address_ram change to q_ram valid; legal range 1..3
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
m0_req  in  1  port 0 request; held until ack
m0_we  in  1  port 0 write (1) / read (0)
m0_addr  in  ADDR_W  port 0 address
m0_wdata  in  DATA_W  port 0 write data
m0_ack  out  1  port 0 one-cycle completion pulse
m0_rdata  out  DATA_W  port 0 read data; valid when m0_ack=1, held afterwards
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  (same as port 0, for port 1)
address_ram  out  ADDR_W  RAM address
data_ram  out  DATA_W  RAM write data
wren_ram  out  1  RAM write enable
q_ram  in  DATA_W  RAM read data
busy  out  1  high whenever state != IDLE
last_grant  out  1  port granted most recently

Behaviour:
- Reset (async, while reset_n=0): state=IDLE. All outputs are 0, except last_grant=1 so port 0 wins the first tie. Any in-flight transaction is aborted with no ack.
- All outputs are registered.
- States: IDLE, WRITE, WAIT, DONE.
- IDLE, no request: remain in IDLE; wren_ram=0.
- IDLE, request(s) present at an edge:
  - Choose the winner: sole requester; on a tie, the port != last_grant (round-robin), or port 0 when FIXED_PRIO=1.
  - Latch owner, address_ram<=addr and data_ram<=wdata; last_grant<=owner.
  - Write: wren_ram<=1, state<=WRITE.
  - Read: wren_ram<=0, cnt<=READ_LATENCY, state<=WAIT.
- WRITE (one cycle): at the next edge, wren_ram<=0, owner ack<=1, state<=DONE. wren_ram is high for exactly one cycle.
- WAIT: cnt decrements each edge. On the edge where cnt==1: owner rdata<=q_ram, owner ack<=1, state<=DONE.
- DONE (one cycle): ack is high; all requests are ignored; ack<=0, state<=IDLE at the next edge.
- Requester rule: on the edge that samples ack=1, the requester deasserts req or presents a new request. The arbiter never double-grants because requests are ignored in DONE.
- Requester inputs are sampled only at the grant edge. Later changes to we/addr/wdata during WRITE/WAIT/DONE are ignored.
- Latency, grant edge to ack visible:
  - write: 1 cycle
  - read: READ_LATENCY cycles
- Throughput: write = 3 cycles/transaction; read = READ_LATENCY+2 cycles/transaction.
- address_ram and data_ram hold their last values in IDLE. The non-owner port's ack and rdata are unchanged.
- Port rdata changes only on that port's read ack. Writes never alter rdata.
- A read of an address written by the immediately preceding transaction returns the new data.
- Round-robin with both ports requesting continuously: grants strictly alternate. FIXED_PRIO=1 may starve port 1 by design.
- Address and data arithmetic: none. All values pass through bit-exact at ADDR_W/DATA_W.

Test Plan:
- Reset: hold reset_n=0 with m0_req=1 -> all acks/rdata/address_ram/data_ram/wren_ram/busy = 0, last_grant=1, no grant until release.
- Port 0 write addr 0x0010 data 0x1234 -> wren_ram high exactly one cycle with address_ram=0x0010, data_ram=0x1234; m0_ack one cycle later. Then port 1 read 0x0010 -> m1_rdata=0x1234 with m1_ack 2 cycles after grant edge.
- Both ports request reads continuously after reset (round-robin) -> grant order 0,1,0,1; last_grant tracks; each ack is a single-cycle pulse; no double grant.
- FIXED_PRIO=1, m0_req held continuously, m1_req also held -> only m0 acked. After m0_req drops, m1 is granted on the next IDLE edge.
- Assert reset_n=0 during WAIT of a port 1 read -> wren_ram/ack drop immediately, busy=0. After release, no m1_ack is produced for the aborted read.
- READ_LATENCY=3, port 0 read addr 0x0005 with RAM model returning 0xBEEF after 3 edges -> m0_ack 3 cycles after grant, m0_rdata=0xBEEF; changing m0_addr mid-WAIT leaves address_ram unchanged.
